ps_loop_ctrl: RTL and testbench

//  Zero-overhead hardware loop sequencer for the program sequencer fetch stage.

---
 rtl/ps_loop_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ps_loop_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_loop_ctrl.sv
// Zero-overhead hardware loop sequencer beside the fetch-address register.
// Optional register readback port and mux are enabled by defining PS_LP_RDBK_EN.
module ps_loop_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 16,
  parameter int LSTK_DEPTH = 4
) (
  input  logic              clk_fetch,
  input  logic              rst,
  input  logic              stallb,
  input  logic [ADDR_W-1:0] ps_faddr,
  input  logic              lp_push,
  input  logic [ADDR_W-1:0] lp_start_add,
  input  logic [ADDR_W-1:0] lp_end_add,
  input  logic [CNT_W-1:0]  lp_cnt,
  input  logic              lp_pop,
  input  logic              lp_flush,
  output logic              lp_redirect,
  output logic [ADDR_W-1:0] lp_redirect_add,
  output logic              lp_done,
  output logic [CNT_W-1:0]  lp_cntr,
  output logic              lp_empty,
  output logic              lp_full,
  output logic [1:0]        lp_stcky
`ifdef PS_LP_RDBK_EN
  ,
  input  logic [1:0]        lp_rd_add,
  output logic [15:0]       lp_rd_dt
`endif
);

  localparam int PTR_W = $clog2(LSTK_DEPTH);
  localparam int SP_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } state_e;

  logic [ADDR_W-1:0] r_start [LSTK_DEPTH];
  logic [ADDR_W-1:0] r_end   [LSTK_DEPTH];
  logic [CNT_W-1:0]  r_cnt   [LSTK_DEPTH];
  logic [SP_W-1:0]   r_sp;
  state_e            r_state;
  logic              r_done;
  logic [1:0]        r_stcky;

  logic [PTR_W-1:0]  w_top_idx;
  logic              w_empty;
  logic              w_full;
  logic [ADDR_W-1:0] w_top_start;
  logic [ADDR_W-1:0] w_top_end;
  logic [CNT_W-1:0]  w_top_cnt;
  logic [CNT_W-1:0]  w_wr_cnt;
  logic              w_match;
  logic              w_redirect;
  logic              w_last;

  state_e            w_state_nxt;
  logic [SP_W-1:0]   w_sp_nxt;
  logic [SP_W-1:0]   w_sp_pop;
  logic              w_wr_en;
  logic [PTR_W-1:0]  w_wr_idx;
  logic              w_dec_en;
  logic [1:0]        w_stcky_nxt;
  logic              w_done_nxt;

  assign w_top_idx   = PTR_W'(r_sp - SP_W'(1));
  assign w_empty     = (r_sp == '0);
  assign w_full      = (r_sp == SP_W'(LSTK_DEPTH));
  assign w_top_start = w_empty ? '0 : r_start[w_top_idx];
  assign w_top_end   = w_empty ? '0 : r_end[w_top_idx];
  assign w_top_cnt   = w_empty ? '0 : r_cnt[w_top_idx];
  assign w_wr_cnt    = (lp_cnt == '0) ? CNT_W'(1) : lp_cnt;

  assign w_match    = (r_state == ST_RUN) && stallb && !w_empty && (ps_faddr == w_top_end);
  assign w_redirect = w_match && (w_top_cnt > CNT_W'(1));
  assign w_last     = w_match && !w_redirect;

  assign lp_redirect     = w_redirect;
  assign lp_redirect_add = w_top_start;
  assign lp_done         = r_done;
  assign lp_cntr         = w_top_cnt;
  assign lp_empty        = w_empty;
  assign lp_full         = w_full;
  assign lp_stcky        = r_stcky;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    w_sp_nxt    = r_sp;
    w_sp_pop    = r_sp;
    w_wr_en     = 1'b0;
    w_wr_idx    = w_top_idx;
    w_dec_en    = 1'b0;
    w_stcky_nxt = r_stcky;
    w_done_nxt  = 1'b0;

    if (stallb) begin
      w_done_nxt = w_last;
      if (lp_flush) begin
        w_sp_nxt = '0;
        if (r_state != ST_HALT) w_state_nxt = ST_IDLE;
      end else if (w_redirect) begin
        w_dec_en = 1'b1;
      end else if (w_last) begin
        // A push on the final pass reuses the slot being freed.
        if (lp_push) w_wr_en  = 1'b1;
        else         w_sp_nxt = r_sp - SP_W'(1);
        w_state_nxt = (lp_push || (r_sp > SP_W'(1))) ? ST_RUN : ST_IDLE;
      end else begin
        if (lp_pop) begin
          if (!w_empty) w_sp_pop = r_sp - SP_W'(1);
          else          w_stcky_nxt[1] = 1'b1;
        end
        w_sp_nxt = w_sp_pop;
        if (lp_push && (r_state != ST_HALT)) begin
          if (w_sp_pop != SP_W'(LSTK_DEPTH)) begin
            w_wr_en  = 1'b1;
            w_wr_idx = w_sp_pop[PTR_W-1:0];
            w_sp_nxt = w_sp_pop + SP_W'(1);
          end else begin
            w_stcky_nxt[0] = 1'b1;
          end
        end
        if (r_state != ST_HALT) begin
          if (w_stcky_nxt[0] && !r_stcky[0]) w_state_nxt = ST_HALT;
          else if (lp_push && w_sp_pop == SP_W'(LSTK_DEPTH)) w_state_nxt = ST_HALT;
          else w_state_nxt = (w_sp_nxt == '0) ? ST_IDLE : ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk_fetch or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_fetch or negedge rst) begin
    if (!rst) begin
      r_sp    <= '0;
      r_done  <= 1'b0;
      r_stcky <= '0;
      // NOTE: the stack is small register storage, so every entry is cleared on reset.
      for (int i = 0; i < LSTK_DEPTH; i++) begin
        r_start[i] <= '0;
        r_end[i]   <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      r_sp    <= w_sp_nxt;
      r_done  <= w_done_nxt;
      r_stcky <= w_stcky_nxt;
      if (w_wr_en) begin
        r_start[w_wr_idx] <= lp_start_add;
        r_end[w_wr_idx]   <= lp_end_add;
        r_cnt[w_wr_idx]   <= w_wr_cnt;
      end
      if (w_dec_en) r_cnt[w_top_idx] <= w_top_cnt - CNT_W'(1);
    end
  end

`ifdef PS_LP_RDBK_EN
  always_comb begin
    lp_rd_dt = '0;
    case (lp_rd_add)
      2'd0:    lp_rd_dt = 16'(w_top_cnt);
      2'd1:    lp_rd_dt = 16'(w_top_start);
      2'd2:    lp_rd_dt = 16'(w_top_end);
      default: lp_rd_dt = 16'({r_sp, r_stcky});
    endcase
  end
`endif

endmodule

// File: tb/tb_ps_loop_ctrl.sv
// Scoreboard bench for ps_loop_ctrl: directed fetch streams queue expected
// redirect/done events; a negedge monitor pops and compares them.
module tb_ps_loop_ctrl;

  logic        clk_fetch = 1'b0;
  logic        rst       = 1'b1;
  logic        stallb    = 1'b1;
  logic [15:0] ps_faddr  = '0;
  logic        lp_push   = 1'b0;
  logic [15:0] lp_start_add = '0;
  logic [15:0] lp_end_add   = '0;
  logic [15:0] lp_cnt    = '0;
  logic        lp_pop    = 1'b0;
  logic        lp_flush  = 1'b0;
  logic        lp_redirect;
  logic [15:0] lp_redirect_add;
  logic        lp_done;
  logic [15:0] lp_cntr;
  logic        lp_empty;
  logic        lp_full;
  logic [1:0]  lp_stcky;
`ifdef PS_LP_RDBK_EN
  logic [1:0]  lp_rd_add = '0;
  logic [15:0] lp_rd_dt;
`endif

  ps_loop_ctrl #(.ADDR_W(16), .CNT_W(16), .LSTK_DEPTH(4)) dut (
    .clk_fetch       (clk_fetch),
    .rst             (rst),
    .stallb          (stallb),
    .ps_faddr        (ps_faddr),
    .lp_push         (lp_push),
    .lp_start_add    (lp_start_add),
    .lp_end_add      (lp_end_add),
    .lp_cnt          (lp_cnt),
    .lp_pop          (lp_pop),
    .lp_flush        (lp_flush),
    .lp_redirect     (lp_redirect),
    .lp_redirect_add (lp_redirect_add),
    .lp_done         (lp_done),
    .lp_cntr         (lp_cntr),
    .lp_empty        (lp_empty),
    .lp_full         (lp_full),
    .lp_stcky        (lp_stcky)
`ifdef PS_LP_RDBK_EN
    ,
    .lp_rd_add       (lp_rd_add),
    .lp_rd_dt        (lp_rd_dt)
`endif
  );

  always #5 clk_fetch = ~clk_fetch;

  typedef enum logic {EV_REDIR, EV_DONE} ev_kind_e;
  typedef struct packed {
    ev_kind_e    kind;
    logic [15:0] addr;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_take(input ev_kind_e k, input logic [15:0] a);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_unexpected: got %s addr 0x%0h expected no event", k.name(), a);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", 32'(k), 32'(e.kind));
      if (k == EV_REDIR) check("sb_redir_add", 32'(a), 32'(e.addr));
    end
  endtask

  // Monitor: done pulses are taken before redirects seen in the same sample.
  always @(negedge clk_fetch) begin
    if (rst) begin
      if (lp_done)     sb_take(EV_DONE, 16'h0);
      if (lp_redirect) sb_take(EV_REDIR, lp_redirect_add);
    end
  end

  task automatic tick();
    @(posedge clk_fetch);
    #1;
    lp_push  = 1'b0;
    lp_pop   = 1'b0;
    lp_flush = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] a, input int redir_to, input bit last);
    stallb   = 1'b1;
    ps_faddr = a;
    if (redir_to >= 0) exp_q.push_back('{kind: EV_REDIR, addr: 16'(redir_to)});
    if (last)          exp_q.push_back('{kind: EV_DONE,  addr: 16'h0});
    tick();
  endtask

  task automatic fetch_span(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) fetch(16'(a), -1, 1'b0);
  endtask

  task automatic push(input logic [15:0] s, input logic [15:0] e, input logic [15:0] c);
    stallb       = 1'b1;
    ps_faddr     = 16'hFFFF;
    lp_push      = 1'b1;
    lp_start_add = s;
    lp_end_add   = e;
    lp_cnt       = c;
    tick();
  endtask

  task automatic pop();
    stallb   = 1'b1;
    ps_faddr = 16'hFFFF;
    lp_pop   = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_empty",    32'(lp_empty),    32'd1);
    check("rst_full",     32'(lp_full),     32'd0);
    check("rst_done",     32'(lp_done),     32'd0);
    check("rst_stcky",    32'(lp_stcky),    32'd0);
    check("rst_cntr",     32'(lp_cntr),     32'd0);
    check("rst_redirect", 32'(lp_redirect), 32'd0);
    @(negedge clk_fetch);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #1;
    do_reset();

    // T1: single loop, three passes.
    push(16'd10, 16'd12, 16'd3);
    check("t1_cntr", 32'(lp_cntr), 32'd3);
    for (int p = 0; p < 3; p++) begin
      fetch(16'd10, -1, 1'b0);
      fetch(16'd11, -1, 1'b0);
      fetch(16'd12, (p < 2) ? 10 : -1, p == 2);
    end
    check("t1_empty", 32'(lp_empty), 32'd1);
    check("t1_done",  32'(lp_done),  32'd1);
    fetch(16'd13, -1, 1'b0);
    check("t1_done_pulse", 32'(lp_done), 32'd0);

    // T2: nested loops, inner pushed on each outer pass.
    push(16'h20, 16'h30, 16'd2);
    for (int p = 0; p < 2; p++) begin
      fetch(16'h20, -1, 1'b0);
      push(16'h22, 16'h24, 16'd3);
      fetch(16'h21, -1, 1'b0);
      for (int q = 0; q < 3; q++) begin
        fetch_span(16'h22, 16'h23);
        fetch(16'h24, (q < 2) ? 16'h22 : -1, q == 2);
      end
      check("t2_outer_cntr", 32'(lp_cntr), (p == 0) ? 32'd2 : 32'd1);
      fetch_span(16'h25, 16'h2F);
      fetch(16'h30, (p == 0) ? 16'h20 : -1, p == 1);
    end
    check("t2_empty", 32'(lp_empty), 32'd1);
    fetch(16'h31, -1, 1'b0);

    // T5: stall at the end address freezes the count and suppresses redirect.
    push(16'h50, 16'h52, 16'd2);
    fetch(16'h50, -1, 1'b0);
    fetch(16'h51, -1, 1'b0);
    stallb   = 1'b0;
    ps_faddr = 16'h52;
    #2;
    check("t5_stall_redir", 32'(lp_redirect), 32'd0);
    tick();
    tick();
    check("t5_stall_cntr", 32'(lp_cntr), 32'd2);
    fetch(16'h52, 16'h50, 1'b0);
    check("t5_cntr_after", 32'(lp_cntr), 32'd1);
    fetch(16'h50, -1, 1'b0);
    fetch(16'h51, -1, 1'b0);
    fetch(16'h52, -1, 1'b1);
    fetch(16'h53, -1, 1'b0);
    check("t5_empty", 32'(lp_empty), 32'd1);

    // T4: underflow, then a zero count behaves as a single pass.
    pop();
    check("t4_stcky", 32'(lp_stcky), 32'd2);
    check("t4_empty", 32'(lp_empty), 32'd1);
    push(16'h40, 16'h41, 16'd0);
    check("t4_cnt0_cntr", 32'(lp_cntr), 32'd1);
    fetch(16'h40, -1, 1'b0);
    fetch(16'h41, -1, 1'b1);
    fetch(16'h42, -1, 1'b0);
    check("t4_empty_after", 32'(lp_empty), 32'd1);

    do_reset();

    // T3: overflow enters HALT; pops still work, pushes and matches do not.
    for (int i = 0; i < 4; i++) push(16'(16'h60 + i), 16'(16'h70 + i), 16'd2);
    check("t3_full",  32'(lp_full),  32'd1);
    check("t3_stcky0", 32'(lp_stcky), 32'd0);
    push(16'h64, 16'h74, 16'd2);
    check("t3_stcky_ovf", 32'(lp_stcky), 32'd1);
    check("t3_full_ovf",  32'(lp_full),  32'd1);
    fetch(16'h73, -1, 1'b0);
    check("t3_halt_cntr", 32'(lp_cntr), 32'd2);
    pop();
    check("t3_pop_full", 32'(lp_full), 32'd0);
    check("t3_pop_add",  32'(lp_redirect_add), 32'h62);
    push(16'h65, 16'h75, 16'd9);
    check("t3_push_ignored", 32'(lp_redirect_add), 32'h62);
    check("t3_stcky_keep",   32'(lp_stcky), 32'd1);
    fetch(16'h72, -1, 1'b0);

    do_reset();

    // T6: reset mid-loop abandons it; flush empties a populated stack.
    push(16'h80, 16'h82, 16'd5);
    fetch(16'h80, -1, 1'b0);
    fetch(16'h81, -1, 1'b0);
    fetch(16'h82, 16'h80, 1'b0);
    fetch(16'h80, -1, 1'b0);
    check("t6_cntr_mid", 32'(lp_cntr), 32'd4);
    rst = 1'b0;
    #2;
    check("t6_rst_empty", 32'(lp_empty), 32'd1);
    check("t6_rst_cntr",  32'(lp_cntr),  32'd0);
    @(negedge clk_fetch);
    rst = 1'b1;
    tick();
    fetch(16'h81, -1, 1'b0);
    fetch(16'h82, -1, 1'b0);
    check("t6_no_loop", 32'(lp_cntr), 32'd0);
    push(16'h90, 16'h9F, 16'd2);
    push(16'hA0, 16'hAF, 16'd3);
    push(16'hB0, 16'hBF, 16'd4);
    check("t6_cntr3", 32'(lp_cntr), 32'd4);
    stallb   = 1'b1;
    ps_faddr = 16'hFFFF;
    lp_flush = 1'b1;
    tick();
    check("t6_flush_empty", 32'(lp_empty), 32'd1);
    check("t6_flush_full",  32'(lp_full),  32'd0);
    fetch(16'hBF, -1, 1'b0);
    fetch(16'hC0, -1, 1'b0);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
